// File: rtl/fifo_drain_ctrl.sv
// Read-domain sequencer: pops one FIFO word at a time and hands it to a
// busy-handshake consumer, with enable gating, pop counting and a sticky timeout.
module fifo_drain_ctrl #(
  parameter int D_SIZE  = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_fifo_empty,
  input  logic [D_SIZE-1:0] i_fifo_rdata,
  output logic              o_fifo_rinc,
  input  logic              i_tx_busy,
  output logic [D_SIZE-1:0] o_tx_data,
  output logic              o_tx_valid,
  output logic              o_active,
  output logic [CNT_W-1:0]  o_pop_cnt,
  output logic              o_timeout
);

  localparam int TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               pop, tmo_hit;
  logic               tx_valid_d, timeout_d;
  logic [D_SIZE-1:0]  tx_data_d;
  logic [CNT_W-1:0]   pop_cnt_d;

  assign pop     = (state_q == IDLE) && i_en && !i_fifo_empty && !i_tx_busy;
  assign tmo_hit = (state_q == WAIT_BUSY) && !i_tx_busy &&
                   (tmo_cnt_q == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (pop) state_d = WAIT_BUSY;
      WAIT_BUSY: if (i_tx_busy) state_d = WAIT_DONE;
                 else if (tmo_hit) state_d = IDLE;
      WAIT_DONE: if (!i_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; the timeout clear on !i_en wins
  // over a timeout firing on the same edge.
  always_comb begin
    tx_valid_d = o_tx_valid;
    tx_data_d  = o_tx_data;
    pop_cnt_d  = o_pop_cnt;
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = o_timeout;
    if (pop) begin
      tx_data_d  = i_fifo_rdata;
      tx_valid_d = 1'b1;
      pop_cnt_d  = o_pop_cnt + CNT_W'(1);
      tmo_cnt_d  = '0;
    end
    if (state_q == WAIT_BUSY) begin
      if (i_tx_busy || tmo_hit) tx_valid_d = 1'b0;
      else                      tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
    end
    if (tmo_hit) timeout_d = 1'b1;
    if (!i_en)   timeout_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_fifo_rinc <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_tx_data   <= '0;
      o_active    <= 1'b0;
      o_pop_cnt   <= '0;
      o_timeout   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      o_fifo_rinc <= pop;
      o_tx_valid  <= tx_valid_d;
      o_tx_data   <= tx_data_d;
      o_active    <= (state_d != IDLE);
      o_pop_cnt   <= pop_cnt_d;
      o_timeout   <= timeout_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: queue-based FIFO, transaction-level reference
// model, a vector table for the timeout path and directed multi-cycle sequences.
module tb_fifo_drain_ctrl;
  localparam int D_SIZE  = 8;
  localparam int CNT_W   = 2;
  localparam int TMO_CYC = 4;

  logic              i_clk = 1'b0;
  logic              i_rstn, i_en, i_fifo_empty, i_tx_busy;
  logic [D_SIZE-1:0] i_fifo_rdata;
  logic              o_fifo_rinc, o_tx_valid, o_active, o_timeout;
  logic [D_SIZE-1:0] o_tx_data;
  logic [CNT_W-1:0]  o_pop_cnt;

  fifo_drain_ctrl #(.D_SIZE(D_SIZE), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_fifo_empty(i_fifo_empty),
    .i_fifo_rdata(i_fifo_rdata), .o_fifo_rinc(o_fifo_rinc), .i_tx_busy(i_tx_busy),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_active(o_active),
    .o_pop_cnt(o_pop_cnt), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  logic [D_SIZE-1:0] fifo_q[$];
  int cons_hold = 0;

  // Reference model: a word is either absent, offered (waiting for acceptance)
  // or accepted (consumer still busy); m_wait counts cycles spent offered.
  int m_phase, m_wait, m_cnt;
  logic m_valid, m_rinc, m_tmo;
  logic [D_SIZE-1:0] m_data;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_wait = 0; m_cnt = 0;
    m_valid = 1'b0; m_rinc = 1'b0; m_tmo = 1'b0; m_data = '0;
  endtask

  task automatic model_step();
    logic fire;
    fire   = 1'b0;
    m_rinc = 1'b0;
    case (m_phase)
      0: if (i_en && fifo_q.size() != 0 && !i_tx_busy) begin
           m_data = fifo_q[0]; m_valid = 1'b1; m_rinc = 1'b1;
           m_cnt = (m_cnt + 1) % (1 << CNT_W); m_wait = 0; m_phase = 1;
         end
      1: if (i_tx_busy) begin
           m_valid = 1'b0; m_phase = 2;
         end else begin
           m_wait++;
           if (m_wait == TMO_CYC) begin
             m_valid = 1'b0; fire = 1'b1; m_phase = 0;
           end
         end
      default: if (!i_tx_busy) m_phase = 0;
    endcase
    if (fire) m_tmo = 1'b1;
    if (!i_en) m_tmo = 1'b0;
  endtask

  task automatic set_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(logic [D_SIZE-1:0] v);
    fifo_q.push_back(v);
    set_fifo();
  endtask

  // One clock: model follows the edge, DUT outputs are compared on the falling edge.
  task automatic cyc();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    chk("valid",  32'(o_tx_valid),  32'(m_valid));
    chk("rinc",   32'(o_fifo_rinc), 32'(m_rinc));
    chk("active", 32'(o_active),    32'(m_phase != 0));
    chk("tmo",    32'(o_timeout),   32'(m_tmo));
    chk("popcnt", 32'(o_pop_cnt),   32'(m_cnt));
    chk("data",   32'(o_tx_data),   32'(m_data));
    if (o_fifo_rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
    set_fifo();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rinc"},   32'(o_fifo_rinc), 0);
    chk({tag, "_valid"},  32'(o_tx_valid),  0);
    chk({tag, "_data"},   32'(o_tx_data),   0);
    chk({tag, "_active"}, 32'(o_active),    0);
    chk({tag, "_cnt"},    32'(o_pop_cnt),   0);
    chk({tag, "_tmo"},    32'(o_timeout),   0);
  endtask

  task automatic do_reset();
    i_rstn = 1'b0; i_en = 1'b0; i_tx_busy = 1'b0; cons_hold = 0;
    fifo_q.delete(); set_fifo();
    m_reset();
    repeat (2) @(negedge i_clk);
    chk_zero("rst");
    i_rstn = 1'b1;
  endtask

  // Consumer that accepts the cycle after valid and stays busy for two edges.
  task automatic cons_step();
    if (cons_hold > 0) begin
      i_tx_busy = 1'b1; cons_hold--;
    end else if (o_tx_valid) begin
      i_tx_busy = 1'b1; cons_hold = 1;
    end else i_tx_busy = 1'b0;
  endtask

  typedef struct {
    logic en, busy, v, r, a, t;
    logic [CNT_W-1:0]  c;
    logic [D_SIZE-1:0] d;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int rinc_n, vcyc, fall, n, bad, found;
    logic busy_at_edge;
    logic [D_SIZE-1:0] got[3];

    //            en    busy  valid rinc  activ tmo   cnt    data
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}; // busy blocks pop
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}; // disabled
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 8'h5A}; // pop
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h5A};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h5A};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h5A};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h5A}; // timeout
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h5A}; // sticky, empty
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h5A}; // cleared by !en

    do_reset();
    push(8'h5A);
    for (int k = 0; k < 9; k++) begin
      i_en = tbl[k].en; i_tx_busy = tbl[k].busy;
      cyc();
      chk("tbl_valid",  32'(o_tx_valid),  32'(tbl[k].v));
      chk("tbl_rinc",   32'(o_fifo_rinc), 32'(tbl[k].r));
      chk("tbl_active", 32'(o_active),    32'(tbl[k].a));
      chk("tbl_tmo",    32'(o_timeout),   32'(tbl[k].t));
      chk("tbl_cnt",    32'(o_pop_cnt),   32'(tbl[k].c));
      chk("tbl_data",   32'(o_tx_data),   32'(tbl[k].d));
    end

    // Single word, consumer busy sampled on edges 3..12.
    do_reset();
    push(8'hA5); i_en = 1'b1;
    rinc_n = 0; vcyc = 0; fall = -1;
    for (int i = 0; i < 20; i++) begin
      i_tx_busy = (i >= 3 && i <= 12);
      cyc();
      rinc_n += int'(o_fifo_rinc);
      vcyc   += int'(o_tx_valid);
      if (fall < 0 && i > 0 && !o_active) fall = i;
    end
    chk("single_rinc_pulses", rinc_n, 1);
    chk("single_valid_cycles", vcyc, 3);
    chk("single_data", 32'(o_tx_data), 32'h A5);
    chk("single_popcnt", 32'(o_pop_cnt), 1);
    chk("single_active_fall", fall, 13);

    // Burst of three words.
    do_reset();
    push(8'h01); push(8'h02); push(8'h03); i_en = 1'b1;
    n = 0; bad = 0;
    for (int i = 0; i < 24; i++) begin
      cons_step();
      busy_at_edge = i_tx_busy;
      cyc();
      if (o_fifo_rinc) begin
        if (n < 3) got[n] = o_tx_data;
        n++;
        if (busy_at_edge) bad++;
      end
    end
    chk("burst_pops", n, 3);
    chk("burst_w0", 32'(got[0]), 32'h01);
    chk("burst_w1", 32'(got[1]), 32'h02);
    chk("burst_w2", 32'(got[2]), 32'h03);
    chk("burst_pop_while_busy", bad, 0);
    chk("burst_fifo_left", fifo_q.size(), 0);
    chk("burst_popcnt", 32'(o_pop_cnt), 3);

    // Enable dropped while word 1 is in WAIT_DONE.
    do_reset();
    push(8'h11); push(8'h22); i_en = 1'b1;
    n = 0; found = 0;
    for (int i = 0; i < 12; i++) begin
      cons_step();
      cyc();
      n += int'(o_fifo_rinc);
      if (!found && o_active && !o_tx_valid) begin i_en = 1'b0; found = 1; end
    end
    chk("gate_pops", n, 1);
    chk("gate_fifo_left", fifo_q.size(), 1);
    chk("gate_idle", 32'(o_active), 0);
    i_en = 1'b1; i_tx_busy = 1'b0; cons_hold = 0;
    cyc();
    chk("gate_repop", 32'(o_fifo_rinc), 1);
    chk("gate_repop_data", 32'(o_tx_data), 32'h22);

    // Counter wrap, then asynchronous reset in WAIT_BUSY.
    do_reset();
    for (int i = 0; i < 5; i++) push(D_SIZE'(8'h30 + i));
    i_en = 1'b1;
    for (int i = 0; i < 30; i++) begin cons_step(); cyc(); end
    chk("wrap_popcnt", 32'(o_pop_cnt), 1);
    chk("wrap_fifo_left", fifo_q.size(), 0);
    push(8'h77); i_tx_busy = 1'b0; cons_hold = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (o_fifo_rinc) found = 1;
    end
    chk("wrap_pop_seen", found, 1);
    #2 i_rstn = 1'b0;
    #1 chk_zero("async");
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("rst_hold_rinc", 32'(o_fifo_rinc), 0);
      chk("rst_hold_valid", 32'(o_tx_valid), 0);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      i_en      = ($urandom_range(0, 7) != 0);
      i_tx_busy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) push(D_SIZE'($urandom));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
